// File: rtl/spi_rx_trig_gen2.sv
// SPI receive trigger: oversamples SS_n/SCLK/MOSI on clk, assembles programmable-length
// words MSB- or LSB-first, exports them, and pulses SPItrig when a chosen word matches.
module spi_rx_trig_gen2 #(
   parameter int MAX_W  = 32,
   parameter int LEN_W  = $clog2(MAX_W + 1),
   parameter int WCNT_W = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              SCLK,
   input  logic              MOSI,
   input  logic              edg,
   input  logic              lsb_first,
   input  logic [LEN_W-1:0]  len,
   input  logic [WCNT_W-1:0] word_sel,
   input  logic [MAX_W-1:0]  mask,
   input  logic [MAX_W-1:0]  match,
   output logic              SPItrig,
   output logic [MAX_W-1:0]  rx_data,
   output logic              rx_valid,
   output logic              frame_err
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_W);

   typedef enum logic {IDLE, RX} state_t;

   state_t state;
   state_t state_nxt;

   logic ss_ff1, ss_ff2, ss_ff3;
   logic sclk_ff1, sclk_ff2, sclk_ff3;
   logic mosi_ff1, mosi_ff2, mosi_ff3;

   logic sclk_rise;
   logic sclk_fall;
   logic start_frame;
   logic end_frame;
   logic do_shift;

   logic              cfg_edg;
   logic              cfg_lsb;
   logic [LEN_W-1:0]  cfg_len;
   logic [WCNT_W-1:0] cfg_word_sel;
   logic [MAX_W-1:0]  cfg_mask;
   logic [MAX_W-1:0]  cfg_match;

   logic [LEN_W-1:0]  len_sat;
   logic [LEN_W-1:0]  bit_cnt;
   logic [LEN_W-1:0]  bit_cnt_inc;
   logic [WCNT_W-1:0] word_cnt;
   logic [MAX_W-1:0]  word_reg;
   logic [MAX_W-1:0]  word_next;
   logic [MAX_W-1:0]  lenmask;
   logic              word_done;
   logic              word_hit;

   // Three-flop synchronisers; SS idles high so a reset never looks like a frame start
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ss_ff1   <= 1'b1;
         ss_ff2   <= 1'b1;
         ss_ff3   <= 1'b1;
         sclk_ff1 <= 1'b0;
         sclk_ff2 <= 1'b0;
         sclk_ff3 <= 1'b0;
         mosi_ff1 <= 1'b0;
         mosi_ff2 <= 1'b0;
         mosi_ff3 <= 1'b0;
      end else begin
         ss_ff1   <= SS_n;
         ss_ff2   <= ss_ff1;
         ss_ff3   <= ss_ff2;
         sclk_ff1 <= SCLK;
         sclk_ff2 <= sclk_ff1;
         sclk_ff3 <= sclk_ff2;
         mosi_ff1 <= MOSI;
         mosi_ff2 <= mosi_ff1;
         mosi_ff3 <= mosi_ff2;
      end
   end

   assign sclk_rise = sclk_ff2 & ~sclk_ff3;
   assign sclk_fall = ~sclk_ff2 & sclk_ff3;
   assign len_sat   = ((len == '0) || (len > MAX_LEN)) ? MAX_LEN : len;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Frame end wins over a coincident SCLK edge, so that edge never reaches the assembler
   always_comb begin
      state_nxt   = state;
      start_frame = 1'b0;
      end_frame   = 1'b0;
      do_shift    = 1'b0;
      case (state)
         IDLE: begin
            if (!ss_ff3) begin
               state_nxt   = RX;
               start_frame = 1'b1;
            end
         end
         RX: begin
            if (ss_ff3) begin
               state_nxt = IDLE;
               end_frame = 1'b1;
            end else begin
               do_shift = cfg_edg ? sclk_rise : sclk_fall;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      lenmask = '0;
      for (int i = 0; i < MAX_W; i++) begin
         lenmask[i] = (LEN_W'(i) < cfg_len);
      end
   end

   assign bit_cnt_inc = bit_cnt + 1'b1;
   assign word_next   = cfg_lsb ? (word_reg | (MAX_W'(mosi_ff3) << bit_cnt))
                                : {word_reg[MAX_W-2:0], mosi_ff3};
   assign word_done   = do_shift && (bit_cnt_inc == cfg_len);
   assign word_hit    = (word_cnt == cfg_word_sel) &&
                        (((word_next ^ cfg_match) & ~cfg_mask & lenmask) == '0);

   // Configuration is captured once per frame; the pins may change freely during RX
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cfg_edg      <= 1'b0;
         cfg_lsb      <= 1'b0;
         cfg_len      <= '0;
         cfg_word_sel <= '0;
         cfg_mask     <= '0;
         cfg_match    <= '0;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         word_reg     <= '0;
      end else if (start_frame) begin
         cfg_edg      <= edg;
         cfg_lsb      <= lsb_first;
         cfg_len      <= len_sat;
         cfg_word_sel <= word_sel;
         cfg_mask     <= mask;
         cfg_match    <= match;
         bit_cnt      <= '0;
         word_cnt     <= '0;
         word_reg     <= '0;
      end else if (do_shift) begin
         if (word_done) begin
            bit_cnt  <= '0;
            word_reg <= '0;
            if (word_cnt != '1) begin
               word_cnt <= word_cnt + 1'b1;
            end
         end else begin
            bit_cnt  <= bit_cnt_inc;
            word_reg <= word_next;
         end
      end
   end

   // Once word_cnt saturates, every later word is treated as the last index
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         SPItrig   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_valid  <= word_done;
         SPItrig   <= word_done && word_hit;
         frame_err <= end_frame && (bit_cnt != '0);
         if (word_done) begin
            rx_data <= word_next & lenmask;
         end
      end
   end

endmodule

// File: tb/tb_spi_rx_trig_gen2.sv
// Directed bench for spi_rx_trig_gen2: a frame-level model predicts every word, trigger
// and frame error from the bit stream, and a per-cycle compare process checks the DUT.
module tb_spi_rx_trig_gen2;

   localparam int MAX_W  = 32;
   localparam int LEN_W  = 6;
   localparam int WCNT_W = 4;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              SS_n = 1'b1;
   logic              SCLK = 1'b0;
   logic              MOSI = 1'b0;
   logic              edg = 1'b1;
   logic              lsb_first = 1'b0;
   logic [LEN_W-1:0]  len = 6'd8;
   logic [WCNT_W-1:0] word_sel = '0;
   logic [MAX_W-1:0]  mask = '0;
   logic [MAX_W-1:0]  match = '0;
   logic              SPItrig;
   logic [MAX_W-1:0]  rx_data;
   logic              rx_valid;
   logic              frame_err;

   spi_rx_trig_gen2 #(.MAX_W(MAX_W), .LEN_W(LEN_W), .WCNT_W(WCNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI),
      .edg(edg), .lsb_first(lsb_first), .len(len), .word_sel(word_sel),
      .mask(mask), .match(match), .SPItrig(SPItrig), .rx_data(rx_data),
      .rx_valid(rx_valid), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] data;
      logic        trig;
   } exp_t;

   int   cyc = 0;
   int   checks = 0;
   int   passes = 0;
   bit   streamQ[$];
   exp_t expQ[$];
   logic expErr = 1'b0;
   logic [31:0] modelData = '0;
   int   rxCnt = 0, trigCnt = 0, errCnt = 0;
   int   validLat = 0, errLat = 0, lastTrigIdx = 0;
   int   lastEdgeCyc = 0, ssRiseCyc = 0;
   int   rx0, trig0, err0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   // Per-cycle comparison against the frame model
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (rx_valid) begin
            rxCnt++;
            validLat = cyc - lastEdgeCyc;
            if (SPItrig) begin
               trigCnt++;
               lastTrigIdx = rxCnt;
            end
            if (expQ.size() == 0) begin
               check("unexpected rx_valid", 64'(rx_valid), 64'd0);
            end else begin
               e = expQ.pop_front();
               check("rx_data", 64'(rx_data), 64'(e.data));
               check("SPItrig", 64'(SPItrig), 64'(e.trig));
               modelData = e.data;
            end
         end else begin
            check("SPItrig without rx_valid", 64'(SPItrig), 64'd0);
            check("rx_data hold", 64'(rx_data), 64'(modelData));
         end
         if (frame_err) begin
            errCnt++;
            errLat = cyc - ssRiseCyc;
            check("frame_err", 64'(frame_err), 64'(expErr));
            expErr = 1'b0;
         end
      end
   end

   task automatic loadStream(input logic [63:0] v, input int n, input bit lsbOrder);
      streamQ.delete();
      for (int i = 0; i < n; i++) streamQ.push_back(lsbOrder ? v[i] : v[n-1-i]);
   endtask

   // Predict words from the bit stream and the configuration present at frame start
   task automatic buildExpect();
      int effLen, nWords, idx;
      logic [31:0] val, lm;
      logic [63:0] one;
      exp_t e;
      effLen = (len == 0 || len > 32) ? 32 : int'(len);
      one = 64'd1;
      lm = 32'((one << effLen) - 64'd1);
      nWords = streamQ.size() / effLen;
      for (int k = 0; k < nWords; k++) begin
         val = '0;
         for (int i = 0; i < effLen; i++) begin
            if (lsb_first) val[i] = streamQ[k*effLen+i];
            else val = (val << 1) | 32'(streamQ[k*effLen+i]);
         end
         idx = (k > 15) ? 15 : k;
         e.data = val;
         e.trig = (idx == int'(word_sel)) && (((val ^ match) & ~mask & lm) == 32'd0);
         expQ.push_back(e);
      end
      expErr = (streamQ.size() % effLen) != 0;
   endtask

   task automatic applyStimulus(input int nBits);
      for (int i = 0; i < nBits; i++) begin
         if (edg) begin
            MOSI = streamQ[i];
            repeat (4) @(negedge clk);
            SCLK = 1'b1;
            lastEdgeCyc = cyc;
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
         end else begin
            SCLK = 1'b1;
            MOSI = streamQ[i];
            repeat (4) @(negedge clk);
            SCLK = 1'b0;
            lastEdgeCyc = cyc;
            repeat (4) @(negedge clk);
         end
      end
   endtask

   task automatic runFrame();
      buildExpect();
      rx0 = rxCnt; trig0 = trigCnt; err0 = errCnt;
      SS_n = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(streamQ.size());
      repeat (4) @(negedge clk);
      SS_n = 1'b1;
      ssRiseCyc = cyc;
      repeat (10) @(negedge clk);
   endtask

   task automatic checkOutput(input string tag, input int er, input int et, input int ee);
      check({tag, " rx_valid count"}, 64'(rxCnt - rx0), 64'(er));
      check({tag, " SPItrig count"}, 64'(trigCnt - trig0), 64'(et));
      check({tag, " frame_err count"}, 64'(errCnt - err0), 64'(ee));
      check({tag, " words outstanding"}, 64'(expQ.size()), 64'd0);
      check({tag, " frame_err outstanding"}, 64'(expErr), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL timeout: simulation did not complete");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      repeat (3) @(negedge clk);
      check("reset SPItrig", 64'(SPItrig), 64'd0);
      check("reset rx_valid", 64'(rx_valid), 64'd0);
      check("reset frame_err", 64'(frame_err), 64'd0);
      check("reset rx_data", 64'(rx_data), 64'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // MSB-first match, then mismatch, then mismatch masked away
      edg = 1'b1; lsb_first = 1'b0; len = 6'd8; word_sel = 4'd0; mask = '0; match = 32'hA5;
      loadStream(64'hA5, 8, 1'b0);
      runFrame();
      checkOutput("T1", 1, 1, 0);
      check("T1 rx_data literal", 64'(rx_data), 64'h0000_00A5);
      check("T1 shift-to-valid latency", 64'(validLat), 64'd3);

      loadStream(64'hA4, 8, 1'b0);
      runFrame();
      checkOutput("T2a", 1, 0, 0);
      check("T2a rx_data literal", 64'(rx_data), 64'hA4);

      mask = 32'h01;
      runFrame();
      checkOutput("T2b", 1, 1, 0);

      // LSB-first 16-bit word, sampled on fall then on rise
      lsb_first = 1'b1; len = 6'd16; edg = 1'b0; mask = '0; match = 32'h1234;
      loadStream(64'h1234, 16, 1'b1);
      runFrame();
      checkOutput("T3a", 1, 1, 0);
      check("T3a rx_data literal", 64'(rx_data), 64'h1234);
      edg = 1'b1;
      runFrame();
      checkOutput("T3b", 1, 1, 0);
      check("T3b rx_data literal", 64'(rx_data), 64'h1234);

      // Word selection, with match changing mid-frame
      lsb_first = 1'b0; len = 6'd8; word_sel = 4'd2; match = 32'h3C;
      loadStream(64'h3C00_3C3C, 32, 1'b0);
      fork
         runFrame();
         begin
            repeat (60) @(negedge clk);
            match = 32'hFF;
         end
      join
      checkOutput("T4", 4, 1, 0);
      check("T4 trigger word index", 64'(lastTrigIdx - rx0), 64'd3);

      // Partial trailing word: the 8 leftover bits would match word_sel=1 if not discarded
      len = 6'd12; word_sel = 4'd1; match = 32'h0DE;
      loadStream(64'hABCDE, 20, 1'b0);
      runFrame();
      checkOutput("T5", 1, 0, 1);
      check("T5 rx_data literal", 64'(rx_data), 64'hABC);
      check("T5 frame_err latency", 64'(errLat), 64'd4);

      // len=0 means full 32-bit words
      len = 6'd0; word_sel = 4'd0; match = 32'hDEAD_BEEF;
      loadStream(64'hDEAD_BEEF, 32, 1'b0);
      runFrame();
      checkOutput("T6a", 1, 1, 0);
      check("T6a rx_data literal", 64'(rx_data), 64'hDEAD_BEEF);

      // Reset part-way into a frame
      rx0 = rxCnt; trig0 = trigCnt; err0 = errCnt;
      loadStream(64'h0F0F_0F0F, 32, 1'b0);
      SS_n = 1'b0;
      repeat (6) @(negedge clk);
      applyStimulus(10);
      rst_n = 1'b0;
      #1;
      check("midreset SPItrig", 64'(SPItrig), 64'd0);
      check("midreset rx_valid", 64'(rx_valid), 64'd0);
      check("midreset frame_err", 64'(frame_err), 64'd0);
      check("midreset rx_data", 64'(rx_data), 64'd0);
      modelData = '0;
      SS_n = 1'b1; SCLK = 1'b0; MOSI = 1'b0;
      repeat (5) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) @(negedge clk);
      checkOutput("T6 reset", 0, 0, 0);

      match = 32'h1234_5678;
      loadStream(64'h1234_5678, 32, 1'b0);
      runFrame();
      checkOutput("T6b", 1, 1, 0);
      check("T6b rx_data literal", 64'(rx_data), 64'h1234_5678);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
